// File: rtl/sparse_compact_mux.sv
// ----------------------------------------------------------------------------
// sparse_compact_mux
//
// Purpose:
//   Accepts a vector of NUM_LANES elements together with a sparsity bitmap and
//   streams out only the lanes whose mask bit is set, one element per beat, in
//   ascending lane order. An all-zero effective mask still produces a single
//   "empty" beat, so every accepted vector yields at least one beat. A new
//   vector may be accepted in the same cycle as the last beat of the previous
//   one, so back-to-back vectors stream without a bubble.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_valid   - input vector valid
//   in_ready   - block accepts a vector this cycle
//   in_data    - NUM_LANES elements, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_mask    - sparse bitmap, bit i set means lane i is nonzero
//   dense_mode - sampled at accept; forces the effective mask to all ones
//   out_valid  - output beat valid
//   out_ready  - consumer accepts the beat
//   out_data   - selected element
//   out_index  - source lane of out_data
//   out_last   - final beat of the current vector
//   out_empty  - beat stands for a vector whose effective mask was all zero
// ----------------------------------------------------------------------------
module sparse_compact_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_LANES-1:0]              in_mask,
    input  logic                              dense_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_LANES)-1:0]      out_index,
    output logic                              out_last,
    output logic                              out_empty
);

    localparam int IDX_WIDTH = $clog2(NUM_LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_LANES*DATA_WIDTH-1:0]   data_q,  data_d;
    logic [NUM_LANES-1:0]              mask_q,  mask_d;
    logic                              empty_q, empty_d;

    logic [IDX_WIDTH-1:0]              sel_idx;
    logic [DATA_WIDTH-1:0]             sel_data;
    logic [NUM_LANES-1:0]              sel_onehot;
    logic                              single_bit;
    logic                              out_hs;
    logic                              accept;
    logic [NUM_LANES-1:0]              eff_mask;

    // Lowest set bit of the remaining mask. Scanning from the top down lets
    // the lowest set lane be the last one to overwrite the selection.
    always_comb begin
        sel_idx    = '0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_idx       = IDX_WIDTH'(i);
                sel_data      = data_q[i*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit (or
    // none) was set; the none case is handled separately by empty_q.
    assign single_bit = ((mask_q & (mask_q - NUM_LANES'(1))) == '0);

    assign eff_mask = dense_mode ? {NUM_LANES{1'b1}} : in_mask;

    // Outputs and next state. Outputs are all zero outside EMIT.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;

        if (state_q == EMIT) begin
            out_valid = 1'b1;
            if (empty_q) begin
                out_last  = 1'b1;
                out_empty = 1'b1;
            end else begin
                out_data  = sel_data;
                out_index = sel_idx;
                out_last  = single_bit;
            end
        end

        out_hs   = out_valid && out_ready;
        in_ready = (state_q == IDLE) || (out_hs && out_last);
        accept   = in_valid && in_ready;

        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        empty_d = empty_q;

        // A new vector takes precedence over retiring the last beat, which is
        // what gives back-to-back streaming with no idle cycle in between.
        if (accept) begin
            state_d = EMIT;
            data_d  = in_data;
            mask_d  = eff_mask;
            empty_d = (eff_mask == '0);
        end else if (out_hs) begin
            mask_d = mask_q & ~sel_onehot;
            if (out_last) begin
                state_d = IDLE;
                data_d  = '0;
                mask_d  = '0;
                empty_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: doc/sparse_compact_mux.md
SPARSE_COMPACT_MUX -- requirements
Module: sparse_compact_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one element (INT8).
REQ-002 SHALL have parameter NUM_LANES, default 8, elements per input vector (>=2).
REQ-003 SHALL derive IDX_WIDTH = clog2(NUM_LANES) locally; it SHALL NOT be a port parameter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  input vector valid.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 in_data  input  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_mask  input  NUM_LANES  sparse index bitmap; bit i=1 means lane i is nonzero.
REQ-011 dense_mode  input  1  sampled at accept; 1 means treat the mask as all ones.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  consumer accepts beat.
REQ-014 out_data  output  DATA_WIDTH  selected element.
REQ-015 out_index  output  IDX_WIDTH  source lane of out_data.
REQ-016 out_last  output  1  final beat of current vector.
REQ-017 out_empty  output  1  beat represents an all-zero-mask vector.

Function
REQ-018 SHALL implement FSM states IDLE and EMIT.
REQ-019 Accept SHALL occur when in_valid and in_ready are both 1; the block captures in_data and the effective mask (dense_mode ? all ones : in_mask) into registers.
REQ-020 in_ready SHALL be 1 in IDLE, and in EMIT only while out_valid, out_ready and out_last are all 1 (back-to-back acceptance).
REQ-021 After an accept, the FSM SHALL be in EMIT on the next cycle; first beat latency is 1 cycle.
REQ-022 In EMIT, out_valid SHALL be 1; out_index SHALL be the lowest set bit of the remaining mask; out_data SHALL be the captured lane at out_index.
REQ-023 out_last SHALL be 1 when the remaining mask has exactly one set bit.
REQ-024 On an out handshake, the block SHALL clear the emitted bit from the remaining mask. If out_last=1 and no accept occurs in that cycle, the FSM SHALL return to IDLE.
REQ-025 If an accept coincides with the last-beat handshake, the new vector SHALL replace the registers and the FSM SHALL stay in EMIT with no bubble.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_index, out_last and out_empty SHALL hold stable.
REQ-027 An accepted all-zero effective mask SHALL produce exactly one beat: out_data=0, out_index=0, out_last=1, out_empty=1.
REQ-028 out_empty SHALL be 0 for every beat of a vector with at least one set mask bit.
REQ-029 Lanes with mask=0 SHALL never appear on the output; beats SHALL be emitted in ascending lane order.
REQ-030 The number of beats per vector SHALL equal popcount(effective mask), or 1 if that popcount is 0.
REQ-031 In IDLE, out_valid SHALL be 0; out_data, out_index, out_last and out_empty SHALL be 0.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE, clear the data and mask registers, and drive out_valid=0, out_data=0, out_index=0, out_last=0, out_empty=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-033 A reset asserted mid-EMIT SHALL discard the remaining beats; no partial vector SHALL resume after reset.
REQ-034 A reset SHALL take priority over a simultaneous accept or handshake.

Verification
REQ-035 NUM_LANES=8, mask=8'b1010_0100, lanes i=0x10+i, out_ready=1 -> beats (idx2,0x12),(idx5,0x15),(idx7,0x17,last); beats on cycles 1 to 3 after accept.
REQ-036 mask=0x00 -> single beat data=0, idx=0, last=1, empty=1; in_ready=1 in the same cycle as that beat.
REQ-037 dense_mode=1, mask=0x00 -> 8 beats, idx 0..7 in order, last on idx7, empty=0.
REQ-038 Back-to-back vectors mask=0x01 then 0x80 with in_valid held high -> beats on consecutive cycles: idx0 last, then idx7 last, no bubble.
REQ-039 out_ready toggled 0/1 every cycle on mask=0xFF -> outputs stable while stalled; 8 beats in 16 cycles; none lost or duplicated.
REQ-040 rst pulsed after the 2nd beat of mask=0xFF -> next cycle out_valid=0, in_ready=1; a following vector mask=0x03 emits idx0, then idx1 last.
